reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- 32-entry general-purpose register file for the single-cycle MIPS CPU.
- Two combinational read ports and one synchronous write port.
- Register 0 is hardwired to zero.
- Sits between instruction decode (register addresses) and the ALU and write-back paths.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 5, register address width; depth is 2**ADDR_WIDTH (32).
- WRITE_BYPASS, 0, when 1 a read of the register being written returns WriteData in the same cycle.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high; clears all registers.
- WriteEnable  input  1  write strobe, sampled at the rising edge of clock.
- ReadReg1  input  ADDR_WIDTH  read port 1 address.
- ReadReg2  input  ADDR_WIDTH  read port 2 address.
- WriteReg  input  ADDR_WIDTH  write address.
- WriteData  input  DATA_WIDTH  write data.
- ReadData1  output  DATA_WIDTH  contents of register ReadReg1.
- ReadData2  output  DATA_WIDTH  contents of register ReadReg2.

Behaviour:
- Interface is fixed: one clock (clock); reset is synchronous and active-high (reset).
- Storage: 2**ADDR_WIDTH registers of DATA_WIDTH bits. No initial-value dependence; contents are undefined until the first reset.
- Reset: at a rising edge with reset=1, every register becomes 0. Reset has priority over a simultaneous write. From the next edge, ReadData1 and ReadData2 read 0 for every address.
- Write: at a rising edge with reset=0, WriteEnable=1 and WriteReg!=0, register[WriteReg] <= WriteData. The new value is visible on the read ports immediately after that edge.
- Writes to register 0 are silently discarded. With WriteEnable=0, no register changes.
- Read: purely combinational with zero latency. ReadData1 = register[ReadReg1] and ReadData2 = register[ReadReg2].
- Reading address 0 always returns 0, regardless of any write attempt or bypass.
- Both ports may read the same address simultaneously; each returns identical data.
- Read-during-write to the same nonzero address, WRITE_BYPASS=0: the port shows the old value until the edge, then the new value.
- Read-during-write to the same nonzero address, WRITE_BYPASS=1: the port shows WriteData combinationally while WriteEnable=1. This path is also gated by reset=0.
- Reset asserted mid-sequence: the pending write at that edge is dropped and all registers clear.
- No X propagation from unwritten registers after reset. Outputs are never registered.

Decomposition:
- Shared package (mips_pkg):
  - REG_ADDR_W = 5, WORD_W = 32, ZERO_REG = 5'd0.
  - Typedefs: reg_addr_t, word_t.
- One natural sub-module: reg_file_read_port.
  - Address decode, zero-register forcing and optional bypass mux for a single port.
  - Instantiated twice (ports 1 and 2).
- Storage array and write logic stay in reg_file.

Test Plan:
- Reset then read: assert reset for one edge, then sweep ReadReg1/ReadReg2 over 0..31 -> all reads 0x00000000.
- Basic write/read:
  - WriteEnable=1, write 0xA5A5A5A5 to r1 at one edge and 0x5A5A5A5A to r2 at the next.
  - Set WriteEnable=0, ReadReg1=1, ReadReg2=2 -> ReadData1=0xA5A5A5A5, ReadData2=0x5A5A5A5A.
- Register 0 protection: WriteEnable=1, WriteReg=0, WriteData=0xFFFFFFFF, one edge; read r0 on both ports -> 0x00000000.
- Write disabled: WriteEnable=0, WriteReg=3, WriteData=0x12345678, one edge -> r3 still 0x00000000.
- Read-during-write: r4=0x11111111, then WriteData=0x22222222 to r4 with ReadReg1=4.
  - WRITE_BYPASS=0: ReadData1=0x11111111 before the edge, 0x22222222 after.
  - WRITE_BYPASS=1: ReadData1=0x22222222 before the edge.
- Reset priority: reset=1 and WriteEnable=1 with WriteReg=5, WriteData=0xDEADBEEF at the same edge -> r5 reads 0x00000000; previously written r1 and r2 also read 0.

Source files
------------

// File: rtl/mips_pkg.sv
// ============================================================================
// Module : mips_pkg
// Brief  : Shared widths, constants and types for the MIPS datapath blocks.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int WORD_W     = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [WORD_W-1:0]     word_t;

endpackage

`default_nettype wire

// File: rtl/reg_file_read_port.sv
// ============================================================================
// Module : reg_file_read_port
// Brief  : One combinational read port with zero-register forcing and an
//          optional same-cycle write bypass.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_file_read_port
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH   = WORD_W,
  parameter int ADDR_WIDTH   = REG_ADDR_W,
  parameter int WRITE_BYPASS = 0
) (
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] regs [2**ADDR_WIDTH],
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] data
);

  logic w_bypass_hit;

  // The bypass is suppressed during reset because the pending write is dropped.
  assign w_bypass_hit = (WRITE_BYPASS != 0) && write_en && !reset && (write_addr == addr);

  always_comb begin
    data = '0;
    if (addr != '0) begin
      if (w_bypass_hit) begin
        data = write_data;
      end else begin
        data = regs[addr];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_file.sv
// ============================================================================
// Module : reg_file
// Brief  : 32 x 32 MIPS register file, two combinational reads, one write.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_file
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH   = WORD_W,
  parameter int ADDR_WIDTH   = REG_ADDR_W,
  parameter int WRITE_BYPASS = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  WriteEnable,
  input  logic [ADDR_WIDTH-1:0] ReadReg1,
  input  logic [ADDR_WIDTH-1:0] ReadReg2,
  input  logic [ADDR_WIDTH-1:0] WriteReg,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2
);

  localparam int c_DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_regs [c_DEPTH];

  // Reset wins over a coincident write; register 0 is never written.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (WriteEnable && (WriteReg != '0)) begin
      r_regs[WriteReg] <= WriteData;
    end
  end

  reg_file_read_port #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .WRITE_BYPASS(WRITE_BYPASS)
  ) u_read_port1 (
    .reset     (reset),
    .addr      (ReadReg1),
    .regs      (r_regs),
    .write_en  (WriteEnable),
    .write_addr(WriteReg),
    .write_data(WriteData),
    .data      (ReadData1)
  );

  reg_file_read_port #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .WRITE_BYPASS(WRITE_BYPASS)
  ) u_read_port2 (
    .reset     (reset),
    .addr      (ReadReg2),
    .regs      (r_regs),
    .write_en  (WriteEnable),
    .write_addr(WriteReg),
    .write_data(WriteData),
    .data      (ReadData2)
  );

endmodule

`default_nettype wire

// File: tb/tb_reg_file.sv
// ============================================================================
// Module : tb_reg_file
// Brief  : Scoreboard bench for reg_file, with and without write bypass.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we  = 1'b0;
  logic [4:0]  ra1 = '0, ra2 = '0, wa = '0;
  logic [31:0] wd  = '0;
  logic [31:0] rd1_nb, rd2_nb, rd1_b, rd2_b;

  always #5 clk = ~clk;

  reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .WRITE_BYPASS(0)) u_dut_nb (
    .clock(clk), .reset(rst), .WriteEnable(we),
    .ReadReg1(ra1), .ReadReg2(ra2), .WriteReg(wa), .WriteData(wd),
    .ReadData1(rd1_nb), .ReadData2(rd2_nb)
  );

  reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .WRITE_BYPASS(1)) u_dut_b (
    .clock(clk), .reset(rst), .WriteEnable(we),
    .ReadReg1(ra1), .ReadReg2(ra2), .WriteReg(wa), .WriteData(wd),
    .ReadData1(rd1_b), .ReadData2(rd2_b)
  );

  typedef struct {
    string       tag;
    logic [31:0] e1_nb, e2_nb, e1_b, e2_b;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [32];
  int          checks = 0;
  int          errors = 0;
  event        sample_ev;

  // Architectural view of a read given the current inputs.
  function automatic logic [31:0] ref_read(input logic [4:0] a, input bit bypass);
    if (a == 5'd0) return 32'h0;
    if (bypass && we && !rst && a == wa) return wd;
    return model[a];
  endfunction

  task automatic cmp(input string tag, input string port, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %h expected %h", tag, port, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(sample_ev);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: sample with empty queue");
      end else begin
        e = sb.pop_front();
        cmp(e.tag, "nb.rd1", rd1_nb, e.e1_nb);
        cmp(e.tag, "nb.rd2", rd2_nb, e.e2_nb);
        cmp(e.tag, "b.rd1",  rd1_b,  e.e1_b);
        cmp(e.tag, "b.rd2",  rd2_b,  e.e2_b);
      end
    end
  end

  // Drive one cycle: apply inputs, check the pre-edge reads, then advance the model.
  task automatic step(input string tag, input logic r, input logic w, input logic [4:0] waddr,
                      input logic [31:0] wdata, input logic [4:0] a1, input logic [4:0] a2);
    exp_t e;
    @(negedge clk);
    rst = r; we = w; wa = waddr; wd = wdata; ra1 = a1; ra2 = a2;
    #1;
    e.tag   = tag;
    e.e1_nb = ref_read(a1, 1'b0);
    e.e2_nb = ref_read(a2, 1'b0);
    e.e1_b  = ref_read(a1, 1'b1);
    e.e2_b  = ref_read(a2, 1'b1);
    sb.push_back(e);
    -> sample_ev;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (w && waddr != 5'd0) begin
      model[waddr] = wdata;
    end
  endtask

  initial begin : stimulus
    logic [4:0] a1, a2, waddr;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    // Reset and the post-reset sweep of every address.
    step("reset", 1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) step("sweep", 1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));

    step("wr_r1", 1'b0, 1'b1, 5'd1, 32'hA5A5A5A5, 5'd0, 5'd0);
    step("wr_r2", 1'b0, 1'b1, 5'd2, 32'h5A5A5A5A, 5'd1, 5'd1);
    step("rd_r1r2", 1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2);

    step("wr_r0", 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    step("rd_r0", 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    step("we_off", 1'b0, 1'b0, 5'd3, 32'h12345678, 5'd3, 5'd3);
    step("rd_r3", 1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd1);

    step("wr_r4", 1'b0, 1'b1, 5'd4, 32'h11111111, 5'd0, 5'd0);
    step("rdw_r4", 1'b0, 1'b1, 5'd4, 32'h22222222, 5'd4, 5'd2);
    step("rd_r4", 1'b0, 1'b0, 5'd0, 32'h0, 5'd4, 5'd4);

    step("rst_prio", 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
    step("rd_r5r1", 1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd1);
    step("rd_r2", 1'b0, 1'b0, 5'd0, 32'h0, 5'd2, 5'd4);

    for (int n = 0; n < 600; n++) begin
      waddr = 5'($urandom_range(0, 31));
      a1    = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      a2    = ($urandom_range(0, 3) == 0) ? a1    : 5'($urandom_range(0, 31));
      step("random", ($urandom_range(0, 47) == 0), 1'($urandom_range(0, 1)), waddr,
           $urandom(), a1, a2);
    end

    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
